// File: rtl/filtro_fir_secuencial_if.sv
// Sample/result handshake of the sequential FIR stage: input strobe and sample
// towards the filter, registered result, load strobe and status flags back.
interface filtro_fir_secuencial_if #(
  parameter int N = 8
);
  logic                muestra_valida;
  logic signed [N-1:0] dato_entrada;
  logic signed [N-1:0] salida;
  logic                carga_n;
  logic                ocupado;
  logic                perdida;

  modport master (
    output muestra_valida, dato_entrada,
    input  salida, carga_n, ocupado, perdida
  );

  modport slave (
    input  muestra_valida, dato_entrada,
    output salida, carga_n, ocupado, perdida
  );
endinterface

// File: rtl/filtro_fir_secuencial.sv
// Sequential-MAC FIR stage: one multiplier, one tap per clock, rounded and
// saturated result delivered with a one-cycle active-low load strobe.
module filtro_fir_secuencial #(
  parameter int N    = 8,
  parameter int F    = 4,
  parameter int TAPS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [TAPS*N-1:0]   coeficientes,
  filtro_fir_secuencial_if.slave bus
);

  localparam int AW = 2*N + $clog2(TAPS);
  localparam int KW = $clog2(TAPS);
  localparam int SH = (F > 0) ? F - 1 : 0;
  localparam logic [KW-1:0]      K_ULT = KW'(TAPS - 1);
  localparam logic signed [AW:0] HALF  = (F > 0) ? ((AW+1)'(1) <<< SH) : '0;
  localparam logic signed [AW:0] MAXV  = (AW+1)'((1 <<< (N-1)) - 1);
  localparam logic signed [AW:0] MINV  = ~MAXV;

  typedef enum logic [1:0] {REPOSO, CALCULO, ENTREGA} estado_t;

  estado_t             estado, estado_sig;
  logic signed [N-1:0] linea [TAPS];
  logic signed [AW-1:0] acc;
  logic [KW-1:0]       k;
  logic signed [N-1:0] salida_q;
  logic                carga_n_q;
  logic                perdida_q;
  logic                ocupado_c;
  logic signed [N-1:0]   coef_k;
  logic signed [2*N-1:0] prod;
  logic signed [AW-1:0]  prod_ext;

  // Round half up: add 2^(F-1), then arithmetic shift right by F.
  function automatic logic signed [AW:0] redondear(input logic signed [AW-1:0] a);
    logic signed [AW:0] t;
    t = $signed({a[AW-1], a}) + HALF;
    return t >>> F;
  endfunction

  function automatic logic signed [N-1:0] saturar(input logic signed [AW:0] r);
    logic signed [AW:0] c;
    if (r > MAXV)      c = MAXV;
    else if (r < MINV) c = MINV;
    else               c = r;
    return c[N-1:0];
  endfunction

  assign coef_k   = coeficientes[k*N +: N];
  assign prod     = linea[k] * coef_k;
  assign prod_ext = $signed({{(AW-2*N){prod[2*N-1]}}, prod});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:  if (bus.muestra_valida) estado_sig = CALCULO;
      CALCULO: if (k == K_ULT)         estado_sig = ENTREGA;
      ENTREGA:                         estado_sig = REPOSO;
      default:                         estado_sig = REPOSO;
    endcase
  end

  always_comb begin
    ocupado_c = (estado != REPOSO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) linea[i] <= '0;
      acc       <= '0;
      k         <= '0;
      salida_q  <= '0;
      carga_n_q <= 1'b1;
      perdida_q <= 1'b0;
    end else begin
      carga_n_q <= (estado != ENTREGA);
      // A strobe while busy is dropped; only the flag records it.
      perdida_q <= bus.muestra_valida && (estado != REPOSO);
      case (estado)
        REPOSO: if (bus.muestra_valida) begin
          linea[0] <= bus.dato_entrada;
          for (int i = 1; i < TAPS; i++) linea[i] <= linea[i-1];
          acc <= '0;
          k   <= '0;
        end
        CALCULO: begin
          acc <= acc + prod_ext;
          k   <= k + 1'b1;
        end
        ENTREGA: salida_q <= saturar(redondear(acc));
        default: ;
      endcase
    end
  end

  assign bus.salida  = salida_q;
  assign bus.carga_n = carga_n_q;
  assign bus.ocupado = ocupado_c;
  assign bus.perdida = perdida_q;

endmodule

// File: tb/tb_filtro_fir_secuencial.sv
// Directed bench for filtro_fir_secuencial: identity, impulse, saturation,
// rounding, overrun and mid-computation reset with hand-computed results.
module tb_filtro_fir_secuencial;

  logic        clk;
  logic        reset;
  logic [39:0] coeficientes;
  int          checks;
  int          failures;
  int          res;
  int          lat;
  int          bajos;

  filtro_fir_secuencial_if #(.N(8)) bus ();

  filtro_fir_secuencial #(.N(8), .F(4), .TAPS(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .coeficientes (coeficientes),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_coef(input int c0, input int c1, input int c2, input int c3, input int c4);
    coeficientes = {8'(c4), 8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic strobe(input int v);
    @(negedge clk);
    bus.muestra_valida = 1'b1;
    bus.dato_entrada   = 8'(v);
    @(negedge clk);
    bus.muestra_valida = 1'b0;
  endtask

  task automatic wait_carga(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.carga_n === 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_sample(input string tag, input int v, input int exp);
    int r;
    int l;
    strobe(v);
    wait_carga(l);
    check({tag, "_latency"}, l, 6);
    r = $signed(bus.salida);
    check(tag, r, exp);
    @(negedge clk);
    check({tag, "_carga_n_high"}, int'(bus.carga_n), 1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.muestra_valida = 1'b0;
    bus.dato_entrada   = '0;
    set_coef(16, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_salida",  int'($signed(bus.salida)), 0);
    check("reset_carga_n", int'(bus.carga_n), 1);
    check("reset_ocupado", int'(bus.ocupado), 0);
    check("reset_perdida", int'(bus.perdida), 0);
    reset = 1'b1;

    // Identity with explicit latency and busy-flag checks
    strobe(32);
    check("ident_ocupado_busy", int'(bus.ocupado), 1);
    wait_carga(lat);
    check("ident_latency", lat, 6);
    res = $signed(bus.salida);
    check("ident_salida", res, 32);
    @(negedge clk);
    check("ident_carga_n_one_cycle", int'(bus.carga_n), 1);
    check("ident_ocupado_idle", int'(bus.ocupado), 0);

    // Impulse response
    do_reset();
    set_coef(16, 8, 4, 2, 1);
    run_sample("imp0", 16, 16);
    run_sample("imp1", 0, 8);
    run_sample("imp2", 0, 4);
    run_sample("imp3", 0, 2);
    run_sample("imp4", 0, 1);
    run_sample("imp5", 0, 0);

    // Positive saturation
    do_reset();
    set_coef(16, 16, 16, 16, 16);
    run_sample("satp1", 127, 127);
    run_sample("satp2", 127, 127);
    run_sample("satp3", 127, 127);
    run_sample("satp4", 127, 127);
    run_sample("satp5", 127, 127);

    // Negative saturation
    do_reset();
    run_sample("satn1", -128, -128);
    run_sample("satn2", -128, -128);
    run_sample("satn3", -128, -128);
    run_sample("satn4", -128, -128);
    run_sample("satn5", -128, -128);

    // Rounding, half rounds up
    do_reset();
    set_coef(8, 0, 0, 0, 0);
    run_sample("round_p1", 1, 1);
    run_sample("round_m1", -1, 0);
    run_sample("round_p3", 3, 2);

    // Overrun: 50 arrives two cycles after the accepted 20
    do_reset();
    set_coef(16, 8, 0, 0, 0);
    strobe(20);
    @(negedge clk);
    check("ovr_perdida_before", int'(bus.perdida), 0);
    bus.muestra_valida = 1'b1;
    bus.dato_entrada   = 8'(50);
    @(negedge clk);
    bus.muestra_valida = 1'b0;
    check("ovr_perdida_pulse", int'(bus.perdida), 1);
    @(negedge clk);
    check("ovr_perdida_cleared", int'(bus.perdida), 0);
    wait_carga(lat);
    check("ovr_latency_rest", lat, 3);
    res = $signed(bus.salida);
    check("ovr_current_result", res, 20);
    @(negedge clk);
    run_sample("ovr_next_no50", 10, 20);

    // Reset in the middle of a computation
    do_reset();
    set_coef(16, 0, 0, 0, 0);
    run_sample("rst_pre", 48, 48);
    strobe(64);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_salida",  int'($signed(bus.salida)), 0);
    check("rst_mid_ocupado", int'(bus.ocupado), 0);
    check("rst_mid_carga_n", int'(bus.carga_n), 1);
    check("rst_mid_perdida", int'(bus.perdida), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    bajos = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.carga_n !== 1'b1) bajos++;
    end
    check("rst_no_carga_pulse", bajos, 0);
    set_coef(16, 16, 16, 16, 16);
    run_sample("rst_fresh", 16, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/filtro_fir_secuencial.md
# filtro_fir_secuencial

Sequential-MAC FIR filter stage of the audio equalizer datapath. It accepts one signed audio sample per input strobe and computes one output sample with a single multiplier, one tap per clock. It presents the result on `salida` together with a one-cycle active-low load strobe `carga_n`. `carga_n` connects directly to the `enable` input of the downstream pipeline register, which loads while its enable is low.

## Interface
- `N`, 8: sample and coefficient width, signed two's complement.
- `F`, 4: fractional bits of the coefficients (Q(N-F).F); 1.0 = 2^F.
- `TAPS`, 5: number of filter taps, 2..16.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `muestra_valida` in 1: one-cycle strobe; `dato_entrada` is valid this cycle.
- `dato_entrada` in N: signed input sample.
- `coeficientes` in TAPS*N: coefficient k at bits [k*N +: N]; must be held stable while `ocupado`=1.
- `salida` out N: signed filtered sample, registered.
- `carga_n` out 1: active-low one-cycle strobe; `salida` is valid and must be loaded downstream.
- `ocupado` out 1: high while a computation is in progress.
- `perdida` out 1: one-cycle pulse when a strobe arrives while `ocupado`=1.

## Operation
- Delay line x[0..TAPS-1], N bits each; x[0] is the newest sample.
- States:
  - REPOSO: idle.
  - CALCULO: one tap per cycle, index k = 0..TAPS-1.
  - ENTREGA: round, saturate and register the result.
- REPOSO, `muestra_valida`=1 at edge E0:
  - x[0] <= `dato_entrada`, x[k] <= x[k-1].
  - Accumulator cleared, k <= 0, state -> CALCULO.
- CALCULO, edges E1..E_TAPS: acc <= acc + x[k]*coef[k] (full 2N-bit signed product), k <= k+1. State -> ENTREGA at E_TAPS.
- ENTREGA, edge E_TAPS+1:
  - `salida` <= sat(round(acc)).
  - `carga_n` <= 0.
  - State -> REPOSO.
- `carga_n` returns to 1 at the next edge.
- Width and arithmetic rules:
  - Accumulator width is 2N+clog2(TAPS) bits; it never overflows.
  - Rounding is round-half-up: add 2^(F-1), then arithmetic right shift by F.
  - Saturation clamps to [-2^(N-1), 2^(N-1)-1].
- `muestra_valida`=1 while not in REPOSO:
  - The sample is discarded and the delay line is unchanged.
  - `perdida`=1 for the following cycle.
  - The computation in progress is unaffected.
- `muestra_valida` is level-sampled. A strobe held for several cycles counts as one accepted sample plus one `perdida` per extra cycle while busy.
- Reset (`reset`=0) is asynchronous, from any state including mid-CALCULO:
  - State -> REPOSO.
  - Delay line, accumulator, k and `salida` go to 0.
  - `carga_n`=1, `ocupado`=0, `perdida`=0.
  - Any partial result is dropped and no `carga_n` pulse is emitted.

## Timing
- Reset values: `salida`=0, `carga_n`=1, `ocupado`=0, `perdida`=0.
- `ocupado`=1 from E0 through E_TAPS+1 (TAPS+1 cycles) and is combinationally derived from the state.
- Latency: the edge sampling the strobe to the edge updating `salida` is TAPS+1 cycles; 6 with defaults.
- `carga_n` is low for exactly one cycle, between E_TAPS+1 and E_TAPS+2. The downstream register captures `salida` at E_TAPS+2.
- The earliest next accepted strobe is the one sampled at E_TAPS+2. Maximum throughput is one sample per TAPS+2 cycles.
- `salida` holds its value between updates.

## Test plan
- Identity (defaults):
  - Stimulus: coef = {16,0,0,0,0}, input 0x20.
  - Required: `salida`=0x20; `carga_n` low exactly 6 edges after the strobe edge, for one cycle.
- Impulse response:
  - Stimulus: coef = {16,8,4,2,1}; input 16, then five 0s, strobes spaced 7 cycles.
  - Required: outputs 16, 8, 4, 2, 1, 0.
- Saturation:
  - Stimulus: coef all 16; five strobes of 127.
  - Required: outputs 127 (no clamp), then 127 on the 2nd–5th (sum 635 clamped).
  - Stimulus: repeat with -128.
  - Required: clamps to -128 (0x80).
- Rounding:
  - Stimulus: coef = {8,0,0,0,0}, inputs 1, -1, 3.
  - Required: outputs 1, 0, 2 (half rounds up).
- Overrun:
  - Stimulus: strobe with value 50 two cycles after an accepted strobe.
  - Required: `perdida` pulses once; the current result is unchanged; the next computation uses a delay line without 50.
- Reset mid-operation:
  - Stimulus: `reset`=0 at E3 of a computation.
  - Required: `salida`=0, `ocupado`=0, no `carga_n` pulse.
  - Stimulus: after release, a fresh identity sample 0x10.
  - Required: `salida`=0x10, with no contribution from older samples.
